p4_cpu: RTL and testbench
=========================

// Module: p4_cpu
// PURPOSE
// - Simple RISC Machine core: 16-bit instruction register, FSM controller, datapath.
// - Datapath: 8x16 register file, A/B/C registers, shifter, ALU and N/V/Z status.
// - Executes one instruction per start request.
// - Top of the P4 CPU; the instruction is presented on `in` by the host or bench.
// PARAMETERS
// - none (widths fixed: 16-bit data/instruction, 8 registers R0-R7)
// PORTS
// - clk    in   1   rising-edge clock; the only clock
// - reset  in   1   synchronous, active-high reset
// - s      in   1   start; level-sampled in WAIT
// - load   in   1   load instruction register from `in`
// - in     in   16  instruction word
// - out    out  16  C register (datapath result)
// - N      out  1   status negative
// - V      out  1   status signed overflow
// - Z      out  1   status zero
// - w      out  1   1 iff FSM is in WAIT
// BEHAVIOUR
// - Reset (sync, at clk edge):
//   - FSM enters WAIT (w=1).
//   - IR, R0-R7, A, B, C clear to 0; out=0, N=V=Z=0.
//   - Reset mid-instruction aborts it immediately; no write occurs.
// - IR loads `in` at the clk edge when load=1 and w=1; load is ignored when w=0.
// - Encoding: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm, [7:0] imm8.
// - sximm8 = sign-extended imm8.
// - Instructions:
//   - 110/10 MOV Rn,#imm8: Rn<=sximm8; C unchanged.
//   - 110/00 MOV Rd,Rm{,sh}: Rd<=C<=sh(Rm).
//   - 101/00 ADD: Rd<=C<=Rn+sh(Rm).
//   - 101/01 CMP: C<=Rn-sh(Rm); update N,V,Z; no register write.
//   - 101/10 AND: Rd<=C<=Rn&sh(Rm).
//   - 101/11 MVN: Rd<=C<=~sh(Rm).
//   - Any other opcode/op pair: no-op.
// - Shifter (sh): 00 none; 01 LSL1 (zero fill); 10 LSR1 (zero fill); 11 ASR1 (copies bit15).
// - Arithmetic: 16-bit wrap-around.
// - N,V,Z change only in the CMP compare state:
//   - Z = (result==0); N = result[15].
//   - V = signed overflow of Rn - sh(Rm).
// - FSM states: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG.
//   - WAIT -> DECODE when s=1.
//   - DECODE: MOV imm -> WRITE_IMM -> WAIT.
//   - DECODE: MOV reg / MVN -> GET_B -> EXEC -> WRITE_REG -> WAIT.
//   - DECODE: ADD/AND -> GET_A -> GET_B -> EXEC -> WRITE_REG -> WAIT.
//   - DECODE: CMP -> GET_A -> GET_B -> EXEC -> WAIT.
//   - DECODE: undefined -> WAIT.
// - Cycles from the edge sampling s=1 until w=1:
//   - MOV imm 3; MOV reg 5; MVN 5; ADD/AND 6; CMP 5; undefined 2.
// - C (out) updates at the end of EXEC.
// - s still 1 on return to WAIT re-executes the same IR (level-sensitive start).
// - s=1 while w=0 is ignored.
// - The same register as Rn and Rm, or as source and destination, is legal.
//   - Sources are captured in A/B before the write.
// CONFIGURATION
// - SRM_SHIFTER_EN defined: shifter implemented as above.
// - SRM_SHIFTER_EN not defined: sh field ignored (always treated as 00); no shifter logic.
// TESTING
// - Reset high 1 cycle -> w=1, out=0x0000, N=V=Z=0.
// - Load 0xD105 (MOV R1,#5), s=1 -> w=1 after 3 cycles.
//   - Then load 0xC009 (MOV R0,R1,LSL#1), s=1 -> out=0x000A, w=1.
// - Load 0xD2FD (MOV R2,#-3), run; load 0xA162 (ADD R3,R1,R2), run -> out=0x0002.
// - Load 0xA901 (CMP R1,R1) -> Z=1,N=0,V=0.
//   - Then load 0xAA01 (CMP R2,R1) -> out=0xFFF8, N=1,Z=0,V=0.
// - Load 0xE30A (undefined 111) with s=1 -> w=1 after 2 cycles; out, flags, registers unchanged.
// - Reset asserted during EXEC of ADD -> next edge w=1, out=0; destination register not written.

Source files
------------

// File: rtl/p4_cpu.sv
// Simple RISC Machine core: IR, FSM controller, 8x16 register file, A/B/C, shifter, ALU, N/V/Z flags.
// Latency: MOV imm 3, MOV reg/MVN/CMP 5, ADD/AND 6, undefined 2 cycles from the s sample to w=1.
// Flow control: s and load are honoured only in WAIT (w=1); SRM_SHIFTER_EN enables the sh field.
module p4_cpu (
   input  logic        clk,
   input  logic        reset,
   input  logic        s,
   input  logic        load,
   input  logic [15:0] in,
   output logic [15:0] out,
   output logic        N,
   output logic        V,
   output logic        Z,
   output logic        w
);

   typedef enum logic [2:0] {
      S_WAIT,
      S_DECODE,
      S_WRITE_IMM,
      S_GET_A,
      S_GET_B,
      S_EXEC,
      S_WRITE_REG
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_ir;
   logic [15:0] r_regs [8];
   logic [15:0] r_a;
   logic [15:0] r_b;
   logic [15:0] r_c;
   logic        r_n;
   logic        r_v;
   logic        r_z;

   logic [2:0]  w_opcode;
   logic [1:0]  w_op;
   logic [2:0]  w_rn;
   logic [2:0]  w_rd;
   logic [2:0]  w_rm;
   logic [15:0] w_sximm8;
   logic        w_is_movi;
   logic        w_is_movr;
   logic        w_is_alu;
   logic        w_is_cmp;
   logic        w_is_mvn;

   logic        w_load_a;
   logic        w_load_b;
   logic        w_load_c;
   logic        w_load_flags;
   logic        w_write_imm;
   logic        w_write_reg;

   logic [15:0] w_bsh;
   logic [15:0] w_alu;
   logic        w_ovf;

   assign w_opcode = r_ir[15:13];
   assign w_op     = r_ir[12:11];
   assign w_rn     = r_ir[10:8];
   assign w_rd     = r_ir[7:5];
   assign w_rm     = r_ir[2:0];
   assign w_sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};

   assign w_is_movi = (w_opcode == 3'b110) && (w_op == 2'b10);
   assign w_is_movr = (w_opcode == 3'b110) && (w_op == 2'b00);
   assign w_is_alu  = (w_opcode == 3'b101);
   assign w_is_cmp  = w_is_alu && (w_op == 2'b01);
   assign w_is_mvn  = w_is_alu && (w_op == 2'b11);

   // Controller: next state and per-state datapath strobes
   always_comb begin
      w_next       = r_state;
      w_load_a     = 1'b0;
      w_load_b     = 1'b0;
      w_load_c     = 1'b0;
      w_load_flags = 1'b0;
      w_write_imm  = 1'b0;
      w_write_reg  = 1'b0;
      case (r_state)
         S_WAIT: begin
            if (s) w_next = S_DECODE;
         end
         S_DECODE: begin
            if (w_is_movi)                 w_next = S_WRITE_IMM;
            else if (w_is_movr || w_is_mvn) w_next = S_GET_B;
            else if (w_is_alu)             w_next = S_GET_A;
            else                           w_next = S_WAIT;
         end
         S_WRITE_IMM: begin
            w_write_imm = 1'b1;
            w_next      = S_WAIT;
         end
         S_GET_A: begin
            w_load_a = 1'b1;
            w_next   = S_GET_B;
         end
         S_GET_B: begin
            w_load_b = 1'b1;
            w_next   = S_EXEC;
         end
         S_EXEC: begin
            w_load_c     = 1'b1;
            w_load_flags = w_is_cmp;
            w_next       = w_is_cmp ? S_WAIT : S_WRITE_REG;
         end
         S_WRITE_REG: begin
            w_write_reg = 1'b1;
            w_next      = S_WAIT;
         end
         default: w_next = S_WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_WAIT;
      else       r_state <= w_next;
   end

`ifdef SRM_SHIFTER_EN
   always_comb begin
      w_bsh = r_b;
      case (r_ir[4:3])
         2'b01:   w_bsh = {r_b[14:0], 1'b0};
         2'b10:   w_bsh = {1'b0, r_b[15:1]};
         2'b11:   w_bsh = {r_b[15], r_b[15:1]};
         default: w_bsh = r_b;
      endcase
   end
`else
   logic w_unused_sh;
   assign w_unused_sh = ^r_ir[4:3];
   assign w_bsh       = r_b;
`endif

   // MOV reg passes the shifted operand straight through; A is stale for it
   always_comb begin
      w_alu = '0;
      if (w_is_movr) begin
         w_alu = w_bsh;
      end else begin
         case (w_op)
            2'b00:   w_alu = r_a + w_bsh;
            2'b01:   w_alu = r_a - w_bsh;
            2'b10:   w_alu = r_a & w_bsh;
            default: w_alu = ~w_bsh;
         endcase
      end
   end

   assign w_ovf = (r_a[15] != w_bsh[15]) && (w_alu[15] != r_a[15]);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ir <= '0;
         r_a  <= '0;
         r_b  <= '0;
         r_c  <= '0;
         r_n  <= 1'b0;
         r_v  <= 1'b0;
         r_z  <= 1'b0;
         for (int i = 0; i < 8; i++) r_regs[i] <= '0;
      end else begin
         if (load && (r_state == S_WAIT)) r_ir <= in;
         if (w_load_a) r_a <= r_regs[w_rn];
         if (w_load_b) r_b <= r_regs[w_rm];
         if (w_load_c) r_c <= w_alu;
         if (w_load_flags) begin
            r_n <= w_alu[15];
            r_z <= (w_alu == 16'h0000);
            r_v <= w_ovf;
         end
         if (w_write_imm)      r_regs[w_rn] <= w_sximm8;
         else if (w_write_reg) r_regs[w_rd] <= r_c;
      end
   end

   assign out = r_c;
   assign N   = r_n;
   assign V   = r_v;
   assign Z   = r_z;
   assign w   = (r_state == S_WAIT);

endmodule

// File: tb/tb_p4_cpu.sv
// Directed bench for p4_cpu: hand-computed results, cycle counts, flags and reset abort.
module tb_p4_cpu;

   logic        clk;
   logic        reset;
   logic        s;
   logic        load;
   logic [15:0] in;
   logic [15:0] out;
   logic        N;
   logic        V;
   logic        Z;
   logic        w;

   int checks   = 0;
   int failures = 0;

`ifdef SRM_SHIFTER_EN
   localparam logic [15:0] EXP_LSL = 16'h000A;
   localparam logic [15:0] EXP_ASR = 16'hFFFE;
   localparam logic [15:0] EXP_LSR = 16'h7FFE;
`else
   localparam logic [15:0] EXP_LSL = 16'h0005;
   localparam logic [15:0] EXP_ASR = 16'hFFFD;
   localparam logic [15:0] EXP_LSR = 16'hFFFD;
`endif

   p4_cpu dut (
      .clk   (clk),
      .reset (reset),
      .s     (s),
      .load  (load),
      .in    (in),
      .out   (out),
      .N     (N),
      .V     (V),
      .Z     (Z),
      .w     (w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
         else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
         end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present an instruction with s=1 for one sampling edge, then count edges until w=1.
   task automatic run(input logic [15:0] ins, input logic ld, input int cyc, input string tag);
      int n;
      @(negedge clk);
      in   = ins;
      load = ld;
      s    = 1'b1;
      n    = 0;
      do begin
         step();
         n++;
         if (n == 1) begin
            s    = 1'b0;
            load = 1'b0;
         end
      end while (w !== 1'b1 && n < 30);
      chk({tag, " cycles"}, n, cyc);
   endtask

   initial begin
      reset = 1'b1;
      s     = 1'b0;
      load  = 1'b0;
      in    = 16'h0000;
      step();
      chk("reset w", w, 1);
      chk("reset out", out, 16'h0000);
      chk("reset N", N, 0);
      chk("reset V", V, 0);
      chk("reset Z", Z, 0);
      @(negedge clk);
      reset = 1'b0;

      run(16'hD105, 1, 3, "MOV R1,#5");
      chk("movi keeps C", out, 16'h0000);
      run(16'hC009, 1, 5, "MOV R0,R1,LSL");
      chk("mov lsl out", out, EXP_LSL);
      chk("mov lsl w", w, 1);

      run(16'hD2FD, 1, 3, "MOV R2,#-3");
      run(16'hA162, 1, 6, "ADD R3,R1,R2");
      chk("add out", out, 16'h0002);

      run(16'hA901, 1, 5, "CMP R1,R1");
      chk("cmp eq out", out, 16'h0000);
      chk("cmp eq Z", Z, 1);
      chk("cmp eq N", N, 0);
      chk("cmp eq V", V, 0);
      run(16'hAA01, 1, 5, "CMP R2,R1");
      chk("cmp neg out", out, 16'hFFF8);
      chk("cmp neg N", N, 1);
      chk("cmp neg Z", Z, 0);
      chk("cmp neg V", V, 0);

      run(16'hE30A, 1, 2, "undefined");
      chk("undef out", out, 16'hFFF8);
      chk("undef N", N, 1);
      chk("undef Z", Z, 0);

      run(16'hB281, 1, 6, "AND R4,R2,R1");
      chk("and out", out, 16'h0005);
      run(16'hB8A3, 1, 5, "MVN R5,R3");
      chk("mvn out", out, 16'hFFFD);
      run(16'hC0C5, 1, 5, "MOV R6,R5");
      chk("mov R5 readback", out, 16'hFFFD);
      chk("mov keeps N", N, 1);

      // Double 64 nine times to reach 0x8000, then 0x8000 - 5 overflows
      run(16'hD740, 1, 3, "MOV R7,#64");
      for (int i = 0; i < 9; i++) run(16'hA7E7, 1, 6, "ADD R7,R7,R7");
      chk("double out", out, 16'h8000);
      run(16'hAF01, 1, 5, "CMP R7,R1");
      chk("cmp ovf out", out, 16'h7FFB);
      chk("cmp ovf V", V, 1);
      chk("cmp ovf N", N, 0);
      chk("cmp ovf Z", Z, 0);

      run(16'hC01A, 1, 5, "MOV R0,R2,ASR");
      chk("asr out", out, EXP_ASR);
      run(16'hC012, 1, 5, "MOV R0,R2,LSR");
      chk("lsr out", out, EXP_LSR);

      // s held high re-executes; load while busy must not replace IR
      @(negedge clk);
      in   = 16'hA361;
      load = 1'b1;
      s    = 1'b1;
      step();
      in = 16'hE30A;
      step();
      step();
      load = 1'b0;
      repeat (3) step();
      chk("rerun first w", w, 1);
      chk("rerun first out", out, 16'h0007);
      step();
      chk("rerun busy w", w, 0);
      s = 1'b0;
      repeat (5) step();
      chk("rerun second w", w, 1);
      chk("rerun second out", out, 16'h000C);

      // Reset while in EXEC of ADD R3,R3,R1
      @(negedge clk);
      in   = 16'hA361;
      load = 1'b1;
      s    = 1'b1;
      step();
      s    = 1'b0;
      load = 1'b0;
      repeat (3) step();
      chk("exec busy w", w, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort w", w, 1);
      chk("abort out", out, 16'h0000);
      chk("abort N", N, 0);
      chk("abort V", V, 0);
      chk("abort Z", Z, 0);
      run(16'hFFFF, 0, 2, "cleared IR");
      run(16'hC003, 1, 5, "MOV R0,R3");
      chk("R3 cleared", out, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
